// File: rtl/multi_digit_counter.sv
// Cascaded up/down digit counter with per-digit wrap limits, load clamping and chain carry/borrow pulses.
// Optional macro MULTI_DIGIT_COUNTER_STOP_EN: saturate at the chain ends instead of wrapping.
module multi_digit_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load,
  input  logic                 tick,
  input  logic                 up,
  input  logic [DIGITS*DW-1:0] init_value,
  input  logic [DIGITS*DW-1:0] limit,
  output logic [DIGITS*DW-1:0] value,
  output logic                 carry,
  output logic                 borrow,
  output logic                 at_zero
);

  localparam int unsigned W = DIGITS * DW;

  logic [W-1:0]  step_value;
  logic [W-1:0]  load_value;
  logic          all_term;
  logic [DW-1:0] dig;
  logic [DW-1:0] lim;
  logic [DW-1:0] init_dig;
  logic          term;

  logic [W-1:0]  value_d;
  logic          carry_d;
  logic          borrow_d;

  // Ripple the step through the chain: a digit moves only while every lower digit is terminal.
  always_comb begin
    step_value = value;
    load_value = '0;
    all_term   = 1'b1;
    dig        = '0;
    lim        = '0;
    init_dig   = '0;
    term       = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      dig      = value[i*DW +: DW];
      lim      = limit[i*DW +: DW];
      init_dig = init_value[i*DW +: DW];
      term     = up ? (dig >= lim) : (dig == '0);
      if (all_term) begin
        if (up) step_value[i*DW +: DW] = term ? '0 : dig + DW'(1);
        else    step_value[i*DW +: DW] = term ? lim : dig - DW'(1);
      end
      all_term = all_term & term;
      load_value[i*DW +: DW] = (init_dig < lim) ? init_dig : lim;
    end
  end

  // Next-state selection: load beats counting; all_term on a step means the whole chain wraps.
  always_comb begin
    value_d  = value;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (load) begin
      value_d = load_value;
    end else if (en && tick) begin
`ifdef MULTI_DIGIT_COUNTER_STOP_EN
      if (!all_term) value_d = step_value;
`else
      value_d  = step_value;
      carry_d  = up & all_term;
      borrow_d = ~up & all_term;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value   <= '0;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      at_zero <= 1'b1;
    end else begin
      value   <= value_d;
      carry   <= carry_d;
      borrow  <= borrow_d;
      at_zero <= (value_d == '0);
    end
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench for multi_digit_counter, two digits of 4 bits with limits {5,9} (00..59).
module tb_multi_digit_counter;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned DW     = 4;
  localparam int unsigned W      = DIGITS * DW;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         load;
  logic         tick;
  logic         up;
  logic [W-1:0] init_value;
  logic [W-1:0] limit;
  logic [W-1:0] value;
  logic         carry;
  logic         borrow;
  logic         at_zero;

  int compared = 0;
  int mismatched = 0;

  multi_digit_counter #(.DIGITS(DIGITS), .DW(DW)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .tick(tick), .up(up),
    .init_value(init_value), .limit(limit),
    .value(value), .carry(carry), .borrow(borrow), .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [W-1:0] v, input logic c,
                             input logic b, input logic z);
    check({tag, ".value"},   value,          v);
    check({tag, ".carry"},   W'(carry),      W'(c));
    check({tag, ".borrow"},  W'(borrow),     W'(b));
    check({tag, ".at_zero"}, W'(at_zero),    W'(z));
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; tick = 1'b0; up = 1'b1;
    init_value = '0; limit = 8'h59;
    edge_step();
    check_state("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // 1: three up ticks, then asynchronous reset between edges
    en = 1'b1; tick = 1'b1; up = 1'b1;
    edge_step(); check("up1", value, 8'h01);
    edge_step(); edge_step();
    check_state("up3", 8'h03, 1'b0, 1'b0, 1'b0);
    tick = 1'b0;
    #2 reset = 1'b1;
    #1 check_state("async_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b0;

    // 2: load 30, count down to 00
    load = 1'b1; init_value = 8'h30;
    edge_step(); check_state("load30", 8'h30, 1'b0, 1'b0, 1'b0);
    load = 1'b0; up = 1'b0; tick = 1'b1;
    edge_step(); check("down29", value, 8'h29);
    for (int i = 0; i < 29; i++) begin
      edge_step();
      check("down_no_borrow", W'(borrow), W'(1'b0));
    end
    tick = 1'b0;
    check_state("down00", 8'h00, 1'b0, 1'b0, 1'b1);

    // 3: down tick at 00
    tick = 1'b1;
    edge_step();
`ifdef MULTI_DIGIT_COUNTER_STOP_EN
    check_state("down_wrap", 8'h00, 1'b0, 1'b0, 1'b1);
`else
    check_state("down_wrap", 8'h59, 1'b0, 1'b1, 1'b0);
`endif
    tick = 1'b0;
    edge_step();
    check("borrow_one_cycle", W'(borrow), W'(1'b0));

    // 4: up tick at 59, then 09 -> 10
    load = 1'b1; init_value = 8'h59;
    edge_step();
    load = 1'b0; up = 1'b1; tick = 1'b1;
    edge_step();
`ifdef MULTI_DIGIT_COUNTER_STOP_EN
    check_state("up_wrap", 8'h59, 1'b0, 1'b0, 1'b0);
`else
    check_state("up_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
`endif
    tick = 1'b0;
    edge_step();
    check("carry_one_cycle", W'(carry), W'(1'b0));
    load = 1'b1; init_value = 8'h09;
    edge_step();
    load = 1'b0; tick = 1'b1;
    edge_step();
    check_state("up_09_to_10", 8'h10, 1'b0, 1'b0, 1'b0);

    // 5: load with tick in the same cycle, clamped
    load = 1'b1; init_value = 8'h7C;
    edge_step();
    check_state("load_clamp", 8'h59, 1'b0, 1'b0, 1'b0);
    load = 1'b0; tick = 1'b0;

    // 6: en=0 freezes counting but not loading
    load = 1'b1; init_value = 8'h24;
    edge_step();
    load = 1'b0; en = 1'b0; tick = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge_step();
      check_state("freeze", 8'h24, 1'b0, 1'b0, 1'b0);
    end
    load = 1'b1; init_value = 8'h13;
    edge_step();
    check("load_en0", value, 8'h13);
    load = 1'b0;

    // zero-limit digit is always terminal and passes the cascade through
    limit = 8'h50; load = 1'b1; init_value = 8'h37; en = 1'b1; tick = 1'b0;
    edge_step();
    check("zero_limit_load", value, 8'h30);
    load = 1'b0; tick = 1'b1; up = 1'b1;
    edge_step();
    check("zero_limit_up", value, 8'h40);
    up = 1'b0;
    edge_step();
    check("zero_limit_down", value, 8'h30);
    tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
